// File: rtl/page_pkg.sv
// Shared types and constants for the page-allocation arbiter slice.
package page_pkg;

  localparam int NUM_PORTS = 16;
  localparam int PORT_W    = 4;
  localparam int ADDR_W    = 11;

  typedef logic [PORT_W-1:0] port_t;
  typedef logic [ADDR_W-1:0] page_addr_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/page_alloc_arbiter_rr_pick16.sv
// Combinational round-robin finder: first set bit of req at or after ptr, wrapping 15 -> 0.
module rr_pick16
  import page_pkg::*;
(
  input  logic [15:0] req,
  input  port_t       ptr,
  output logic        found,
  output port_t       idx
);

  port_t probe;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    probe = '0;
    for (int i = 0; i < 16; i++) begin
      probe = ptr + port_t'(i);
      if (!found && req[probe]) begin
        found = 1'b1;
        idx   = probe;
      end
    end
  end

endmodule

// File: rtl/page_alloc_arbiter.sv
// Round-robin arbiter sharing the null-page FIFO and per-port page accounting among 16 ports.
//
// Handshake: req is a level request; a grant is a one-cycle gnt_valid pulse carrying
// gnt_port/gnt_addr, and the granted port is masked while gnt_valid is high so it can
// drop req without being granted twice. wr_op/rd_op are single-cycle commands to the
// state block, which applies them at the next edge.
module page_alloc_arbiter #(
  parameter int NUM_PORTS    = 16,
  parameter int ADDR_WIDTH   = 11,
  parameter int PORT_QUOTA   = 512,
  parameter int FREE_RESERVE = 0,
  parameter int INIT_CYCLES  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_PORTS-1:0]  req,
  output logic                  gnt_valid,
  output page_pkg::port_t       gnt_port,
  output logic [ADDR_WIDTH-1:0] gnt_addr,
  input  logic                  rel_valid,
  input  page_pkg::port_t       rel_port,
  input  logic [ADDR_WIDTH-1:0] rel_addr,
  output logic                  wr_op,
  output page_pkg::port_t       wr_port,
  output logic                  rd_op,
  output page_pkg::port_t       rd_port,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output page_pkg::port_t       request_port,
  input  logic [ADDR_WIDTH-1:0] page_amount,
  input  logic [ADDR_WIDTH-1:0] null_ptr,
  input  logic [ADDR_WIDTH-1:0] free_space
);

  import page_pkg::*;

  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam logic [INIT_W-1:0]     INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] QUOTA     = ADDR_WIDTH'(PORT_QUOTA);
  localparam logic [ADDR_WIDTH-1:0] RESERVE   = ADDR_WIDTH'(FREE_RESERVE);

  fsm_state_t              state_q, state_d;
  logic [INIT_W-1:0]       init_cnt_q, init_cnt_d;
  port_t                   rr_ptr_q, rr_ptr_d;
  logic                    gnt_valid_q, gnt_valid_d;
  port_t                   gnt_port_q, gnt_port_d;
  logic [ADDR_WIDTH-1:0]   gnt_addr_q, gnt_addr_d;

  logic [NUM_PORTS-1:0]    eff_req;
  logic                    cand_found;
  port_t                   cand_idx;
  logic                    grant;

  // The port granted last cycle is hidden until it has had a chance to drop req.
  always_comb begin
    eff_req = req;
    if (gnt_valid_q) eff_req[gnt_port_q] = 1'b0;
  end

  rr_pick16 u_pick (
    .req   (eff_req),
    .ptr   (rr_ptr_q),
    .found (cand_found),
    .idx   (cand_idx)
  );

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_valid_d  = 1'b0;
    gnt_port_d   = gnt_port_q;
    gnt_addr_d   = gnt_addr_q;
    grant        = 1'b0;
    request_port = cand_idx;

    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == INIT_LAST) state_d = RUN;
      end
      RUN: begin
        grant = cand_found && (page_amount < QUOTA) && (free_space > RESERVE);
        // Advance past every candidate so a quota-blocked port cannot stall the rest.
        if (cand_found) rr_ptr_d = cand_idx + port_t'(1);
      end
      default: state_d = INIT;
    endcase

    if (grant) begin
      gnt_valid_d = 1'b1;
      gnt_port_d  = cand_idx;
      gnt_addr_d  = null_ptr;
    end
  end

  assign wr_op   = grant;
  assign wr_port = grant ? cand_idx : '0;
  assign rd_op   = rel_valid & rst_n;
  assign rd_port = rel_port;
  assign rd_addr = rel_addr;

  assign gnt_valid = gnt_valid_q;
  assign gnt_port  = gnt_port_q;
  assign gnt_addr  = gnt_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      rr_ptr_q    <= '0;
      gnt_valid_q <= 1'b0;
      gnt_port_q  <= '0;
      gnt_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_port_q  <= gnt_port_d;
      gnt_addr_q  <= gnt_addr_d;
    end
  end

endmodule

// File: tb/tb_page_alloc_arbiter.sv
// Self-checking bench for page_alloc_arbiter: reference arbiter model plus grant scoreboard.
module tb_page_alloc_arbiter;
  import page_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        gnt_valid;
  port_t       gnt_port;
  page_addr_t  gnt_addr;
  logic        rel_valid;
  port_t       rel_port;
  page_addr_t  rel_addr;
  logic        wr_op;
  port_t       wr_port;
  logic        rd_op;
  port_t       rd_port;
  page_addr_t  rd_addr;
  port_t       request_port;
  page_addr_t  page_amount;
  page_addr_t  null_ptr;
  page_addr_t  free_space;

  page_addr_t  pa_mem [16];
  assign page_amount = pa_mem[request_port];

  page_alloc_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt_valid(gnt_valid), .gnt_port(gnt_port), .gnt_addr(gnt_addr),
    .rel_valid(rel_valid), .rel_port(rel_port), .rel_addr(rel_addr),
    .wr_op(wr_op), .wr_port(wr_port),
    .rd_op(rd_op), .rd_port(rd_port), .rd_addr(rd_addr),
    .request_port(request_port), .page_amount(page_amount),
    .null_ptr(null_ptr), .free_space(free_space)
  );

  always #5 clk = ~clk;

  logic [14:0] exp_q [$];
  port_t       gnt_log [$];
  int          checks = 0;
  int          errors = 0;
  int          n_wr = 0;
  int          n_gv = 0;

  bit    m_run;
  int    m_cnt;
  port_t m_rr;
  bit    m_gv;
  port_t m_gport;

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_rr = '0; m_gv = 0; m_gport = '0;
    exp_q.delete();
  endtask

  // One clock: entered at negedge with inputs set; returns at the next negedge.
  task automatic cycle();
    logic [15:0] eff;
    bit          found;
    bit          grant;
    port_t       cand;
    port_t       k;
    logic [14:0] e;
    null_ptr = page_addr_t'($urandom_range(0, 2047));
    #1;
    eff = req;
    if (m_gv) eff[m_gport] = 1'b0;
    found = 0; cand = '0;
    for (int i = 0; i < 16; i++) begin
      k = m_rr + port_t'(i);
      if (!found && eff[k]) begin found = 1; cand = k; end
    end
    grant = m_run && found && (pa_mem[cand] < 11'd512) && (free_space > 11'd0);
    checks++;
    if (request_port !== cand) begin
      errors++; $display("FAIL request_port: got %0d expected %0d", request_port, cand);
    end
    checks++;
    if (wr_op !== grant) begin
      errors++; $display("FAIL wr_op: got %b expected %b (cand %0d)", wr_op, grant, cand);
    end
    if (grant) begin
      checks++;
      if (wr_port !== cand) begin
        errors++; $display("FAIL wr_port: got %0d expected %0d", wr_port, cand);
      end
      exp_q.push_back({cand, null_ptr});
    end
    checks++;
    if (rd_op !== rel_valid || (rel_valid && (rd_port !== rel_port || rd_addr !== rel_addr))) begin
      errors++; $display("FAIL release: got op %b port %0d addr %0d expected op %b port %0d addr %0d",
                         rd_op, rd_port, rd_addr, rel_valid, rel_port, rel_addr);
    end
    if (wr_op === 1'b1) n_wr++;
    m_gv = grant;
    if (grant) m_gport = cand;
    if (m_run && found) m_rr = cand + port_t'(1);
    if (!m_run) begin
      if (m_cnt == 15) m_run = 1; else m_cnt++;
    end
    @(posedge clk);
    #1;
    if (grant) pa_mem[cand] = pa_mem[cand] + 11'd1;
    if (rel_valid) pa_mem[rel_port] = pa_mem[rel_port] - 11'd1;
    checks++;
    if (gnt_valid === 1'b1) begin
      n_gv++;
      gnt_log.push_back(gnt_port);
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL gnt_unexpected: got port %0d addr %0d expected no grant", gnt_port, gnt_addr);
      end else begin
        e = exp_q.pop_front();
        if ({gnt_port, gnt_addr} !== e) begin
          errors++; $display("FAIL gnt_data: got port %0d addr %0d expected port %0d addr %0d",
                             gnt_port, gnt_addr, e[14:11], e[10:0]);
        end
      end
    end else if (gnt_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL gnt_missing: got gnt_valid %b expected %0d pending grant(s)", gnt_valid, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (dut.rr_ptr_q !== m_rr) begin
      errors++; $display("FAIL rr_ptr: got %0d expected %0d", dut.rr_ptr_q, m_rr);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    req = '0; rel_valid = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 16'hFFFF; rel_valid = 1'b1; rel_port = 4'd3; rel_addr = 11'd5;
    free_space = 11'd100; null_ptr = '0;
    for (int i = 0; i < 16; i++) pa_mem[i] = '0;
    #3;
    checks++;
    if (gnt_valid !== 1'b0 || gnt_port !== 4'd0 || gnt_addr !== 11'd0) begin
      errors++; $display("FAIL reset_gnt: got %b/%0d/%0d expected 0/0/0", gnt_valid, gnt_port, gnt_addr);
    end
    checks++;
    if (wr_op !== 1'b0 || rd_op !== 1'b0) begin
      errors++; $display("FAIL reset_ops: got wr %b rd %b expected 0 0", wr_op, rd_op);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; rel_valid = 1'b0;
    model_reset();
  endtask

  task automatic test_init_and_rr();
    int wr0;
    req = 16'hFFFF; free_space = 11'd100;
    wr0 = n_wr;
    repeat (16) cycle();
    checks++;
    if (n_wr != wr0) begin
      errors++; $display("FAIL init_no_grant: got %0d wr_op expected 0", n_wr - wr0);
    end
    gnt_log.delete();
    repeat (17) cycle();
    checks++;
    if (gnt_log.size() != 17) begin
      errors++; $display("FAIL rr_count: got %0d grants expected 17", gnt_log.size());
    end
    for (int i = 0; i < gnt_log.size() && i < 17; i++) begin
      checks++;
      if (gnt_log[i] !== port_t'(i % 16)) begin
        errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, gnt_log[i], i % 16);
      end
    end
  endtask

  task automatic test_quota_single();
    int wr0;
    drain();
    pa_mem[5] = 11'd511; req = 16'h0020; wr0 = n_wr;
    repeat (4) cycle();
    checks++;
    if (n_wr - wr0 != 1) begin
      errors++; $display("FAIL quota_single: got %0d grants expected 1", n_wr - wr0);
    end
  endtask

  task automatic test_quota_fairness();
    int g3, g9;
    drain();
    pa_mem[3] = 11'd512; pa_mem[9] = 11'd0; req = 16'h0208;
    gnt_log.delete();
    repeat (20) cycle();
    g3 = 0; g9 = 0;
    foreach (gnt_log[i]) begin
      if (gnt_log[i] == 4'd3) g3++;
      if (gnt_log[i] == 4'd9) g9++;
    end
    checks++;
    if (g3 != 0) begin
      errors++; $display("FAIL quota_port3: got %0d grants expected 0", g3);
    end
    checks++;
    if (g9 < 9) begin
      errors++; $display("FAIL starve_port9: got %0d grants expected at least 9", g9);
    end
  endtask

  task automatic test_release_blocks();
    int wr0;
    drain();
    pa_mem[2] = 11'd10; req = 16'h0004;
    free_space = 11'd0; rel_valid = 1'b1; rel_port = 4'd2; rel_addr = 11'd100;
    wr0 = n_wr;
    cycle();
    checks++;
    if (n_wr != wr0) begin
      errors++; $display("FAIL release_no_grant: got %0d wr_op expected 0", n_wr - wr0);
    end
    free_space = 11'd1; rel_valid = 1'b0;
    gnt_log.delete();
    cycle();
    checks++;
    if (n_wr - wr0 != 1 || gnt_log.size() != 1 || gnt_log[0] !== 4'd2) begin
      errors++; $display("FAIL release_then_grant: got %0d wr_op %0d grants expected 1 grant to port 2",
                         n_wr - wr0, gnt_log.size());
    end
    free_space = 11'd50;
  endtask

  task automatic test_single_grant_mask();
    int wr0, gv0;
    drain();
    pa_mem[7] = 11'd0; req = 16'h0080;
    wr0 = n_wr; gv0 = n_gv; gnt_log.delete();
    cycle();
    cycle();
    req = '0;
    repeat (2) cycle();
    checks++;
    if (n_wr - wr0 != 1 || n_gv - gv0 != 1) begin
      errors++; $display("FAIL mask: got wr %0d gnt %0d expected 1 1", n_wr - wr0, n_gv - gv0);
    end
    checks++;
    if (gnt_log.size() != 1 || gnt_log[0] !== 4'd7) begin
      errors++; $display("FAIL mask_port: got %0d grants expected 1 to port 7", gnt_log.size());
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 16; i++) pa_mem[i] = '0;
    req = 16'hFFFF; free_space = 11'd100;
    repeat (3) cycle();
    checks++;
    if (gnt_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_gnt: got %b expected 1", gnt_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt_valid !== 1'b0 || gnt_port !== 4'd0 || gnt_addr !== 11'd0 || wr_op !== 1'b0) begin
      errors++; $display("FAIL async_reset: got gnt %b port %0d addr %0d wr %b expected 0 0 0 0",
                         gnt_valid, gnt_port, gnt_addr, wr_op);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    gnt_log.delete();
    repeat (16) cycle();
    checks++;
    if (gnt_log.size() != 0) begin
      errors++; $display("FAIL reinit_no_grant: got %0d grants expected 0", gnt_log.size());
    end
    cycle();
    checks++;
    if (gnt_log.size() != 1 || gnt_log[0] !== 4'd0) begin
      errors++; $display("FAIL restart_port0: got %0d grants expected 1 to port 0", gnt_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_init_and_rr();
    test_quota_single();
    test_quota_fairness();
    test_release_blocks();
    test_single_grant_mask();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
